// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- general-purpose register file, write-back end of the pipeline.
//
// One synchronous write port takes the MEM/WB destination triple. Two
// independent combinational read ports serve ID-stage operand fetch.
// Register 0 always reads as zero, and writes to it are dropped.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read that matches the write being presented in the same
//               cycle returns wdata directly. This removes the RAW hazard
//               for instructions three apart.
//   undefined : reads always return the stored array contents, so a write
//               becomes visible on the following cycle.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  register index width
//   NREGS   register count, must equal 1 << ADDR_W
//
// Ports
//   clk     in   1       clock; all state updates on the rising edge
//   rst     in   1       synchronous reset, active-low; clears every register
//                        and forces both read ports to zero while low
//   we      in   1       write enable
//   waddr   in   ADDR_W  write register index
//   wdata   in   DATA_W  write data
//   re1     in   1       read port 1 enable
//   raddr1  in   ADDR_W  read port 1 index
//   rdata1  out  DATA_W  read port 1 data (combinational)
//   re2     in   1       read port 2 enable
//   raddr2  in   ADDR_W  read port 2 index
//   rdata2  out  DATA_W  read port 2 data (combinational)
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    // A write is committed only outside reset and never to register 0.
    logic wr_commit;
    assign wr_commit = rst && we && (waddr != '0);

    // Read-port resolution, in priority order:
    //   reset, read disabled, register 0, bypass hit (optional), stored value.
    // The stored value is passed in so that both ports share one definition.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_n_i,
        input logic              re_i,
        input logic [ADDR_W-1:0] ra_i,
        input logic              byp_hit_i,
        input logic [DATA_W-1:0] byp_data_i,
        input logic [DATA_W-1:0] stored_i
    );
        if (!rst_n_i || !re_i || ra_i == '0)
            return '0;
        if (byp_hit_i)
            return byp_data_i;
        return stored_i;
    endfunction

    // Bypass hits are computed per port. Without the feature they are tied
    // low, and the read path collapses to the plain array lookup.
    logic hit1, hit2;
`ifdef REGFILE_BYPASS_EN
    assign hit1 = wr_commit && (raddr1 == waddr);
    assign hit2 = wr_commit && (raddr2 == waddr);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // ---- storage: commit at rising edge; reset wins over any write ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_commit) begin
            regs[waddr] <= wdata;
        end
    end

    // ---- combinational read ports ----
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        rdata1 = read_port(rst, re1, raddr1, hit1, wdata, regs[raddr1]);
        rdata2 = read_port(rst, re2, raddr2, hit2, wdata, regs[raddr2]);
    end

endmodule
